// File: rtl/ser_des_pkg.sv
// ser_des_pkg: shared FSM state types and line-level constants for param_ser_des.
// SER_DES_PARITY_EN adds the parity states.
package ser_des_pkg;
`ifdef SER_DES_PARITY_EN
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR} rx_state_t;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA} rx_state_t;
`endif
    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_BIT  = 1'b0;
endpackage

// File: rtl/ser_des_rx.sv
// ser_des_rx: deserializer that waits for a start bit, then assembles WIDTH data bits.
// SER_DES_PARITY_EN adds a trailing even-parity check.
module ser_des_rx
    import ser_des_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_par_err
);
    localparam int CW = $clog2(WIDTH);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] nxt;
    logic             last;

    // LSB-first fills from the top so the first bit ends up at bit 0
    assign nxt  = LSB_FIRST ? {ser_in, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], ser_in};
    assign last = cnt == CW'(WIDTH - 1);

`ifndef SER_DES_PARITY_EN
    assign rx_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            sh       <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
`ifdef SER_DES_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                RX_IDLE: if (ser_in == START_BIT) begin
                    state <= RX_DATA;
                    cnt   <= '0;
                end
                RX_DATA: begin
                    sh  <= nxt;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
`ifdef SER_DES_PARITY_EN
                        state <= RX_PAR;
`else
                        state    <= RX_IDLE;
                        rx_data  <= nxt;
                        rx_valid <= 1'b1;
`endif
                    end
                end
`ifdef SER_DES_PARITY_EN
                RX_PAR: begin
                    state      <= RX_IDLE;
                    rx_data    <= sh;
                    rx_valid   <= 1'b1;
                    rx_par_err <= (^sh) ^ ser_in;
                end
`endif
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/param_ser_des.sv
// param_ser_des: framed serializer (start bit + WIDTH data bits) with a matching deserializer.
// SER_DES_PARITY_EN appends an even-parity bit to every frame.
module param_ser_des
    import ser_des_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    input  logic             ser_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_par_err
);
    localparam int CW = $clog2(WIDTH);

    tx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] shifted;
    logic             head;
    logic             last;
`ifdef SER_DES_PARITY_EN
    logic             par;
`endif

    assign head    = LSB_FIRST ? sh[0] : sh[WIDTH-1];
    assign shifted = LSB_FIRST ? sh >> 1 : sh << 1;
    assign last    = cnt == CW'(WIDTH - 1);

    // cnt tracks which data bit is currently on the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            sh       <= '0;
            ser_out  <= IDLE_BIT;
            tx_ready <= 1'b1;
`ifdef SER_DES_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    ser_out <= tx_valid ? START_BIT : IDLE_BIT;
                    if (tx_valid) begin
                        sh       <= tx_data;
                        state    <= TX_START;
                        tx_ready <= 1'b0;
`ifdef SER_DES_PARITY_EN
                        par      <= ^tx_data;
`endif
                    end
                end
                TX_START: begin
                    ser_out <= head;
                    sh      <= shifted;
                    cnt     <= '0;
                    state   <= TX_DATA;
                end
                TX_DATA: begin
                    if (last) begin
                        cnt <= '0;
`ifdef SER_DES_PARITY_EN
                        ser_out <= par;
                        state   <= TX_PAR;
`else
                        ser_out  <= IDLE_BIT;
                        state    <= TX_IDLE;
                        tx_ready <= 1'b1;
`endif
                    end else begin
                        ser_out <= head;
                        sh      <= shifted;
                        cnt     <= cnt + 1'b1;
                    end
                end
`ifdef SER_DES_PARITY_EN
                TX_PAR: begin
                    ser_out  <= IDLE_BIT;
                    state    <= TX_IDLE;
                    tx_ready <= 1'b1;
                end
`endif
                default: begin
                    state    <= TX_IDLE;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

    ser_des_rx #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_par_err (rx_par_err)
    );
endmodule
